// File: rtl/weight_controller.sv
// Fetches od1/od2 3x3 kernels for one input channel from weight SRAM into two register banks.
// One read per cycle; returning data is tagged {bank, tap} so any RD_LAT lands in the right slot.
module weight_controller #(
  parameter int DW     = 8,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              weight_prepare_i,
  input  logic              weight_start_i,
  input  logic [7:0]        weight_od1_i,
  input  logic [7:0]        weight_od2_i,
  input  logic [3:0]        weight_id_i,
  input  logic [7:0]        total_od_i,
  output logic              mem_ren_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DW-1:0]     mem_rdata_i,
  output logic              weight_ready_o,
  output logic              w_valid_o,
  output logic [9*DW-1:0]   w1_o,
  output logic [9*DW-1:0]   w2_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH1,
    S_FETCH2,
    S_DRAIN,
    S_READY,
    S_ACTIVE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]        r_od1;
  logic [7:0]        r_od2;
  logic [3:0]        r_id;
  logic              r_od2_v;
  logic [3:0]        r_k;
  logic [9*DW-1:0]   r_bank1;
  logic [9*DW-1:0]   r_bank2;

  logic [RD_LAT-1:0] r_pipe_vld;
  logic [RD_LAT-1:0] r_pipe_bank;
  logic [3:0]        r_pipe_k [RD_LAT];

  logic              w_fetching;
  logic              w_abort;
  logic              w_more;
  logic              w_od2_v_new;
  logic              w_start_fetch;
  logic [7:0]        w_od;
  logic [ADDR_W-1:0] w_addr;

  assign w_fetching    = (r_state == S_FETCH1) || (r_state == S_FETCH2);
  assign w_od2_v_new   = (weight_od2_i < total_od_i);
  assign w_start_fetch = (r_state == S_IDLE) && weight_prepare_i;
  assign w_abort       = (w_fetching || (r_state == S_DRAIN)) && !weight_prepare_i;

  assign w_od   = (r_state == S_FETCH2) ? r_od2 : r_od1;
  assign w_addr = ADDR_W'({w_od, r_id}) * ADDR_W'(9) + ADDR_W'(r_k);

  // Reads still in flight after this cycle; the last stage is being written now.
  always_comb begin
    w_more = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      w_more = w_more | r_pipe_vld[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (weight_prepare_i) w_state_nxt = S_FETCH1;
      end
      S_FETCH1: begin
        if (!weight_prepare_i)  w_state_nxt = S_IDLE;
        else if (r_k == 4'd8)   w_state_nxt = r_od2_v ? S_FETCH2 : S_DRAIN;
      end
      S_FETCH2: begin
        if (!weight_prepare_i)  w_state_nxt = S_IDLE;
        else if (r_k == 4'd8)   w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!weight_prepare_i)  w_state_nxt = S_IDLE;
        else if (!w_more)       w_state_nxt = S_READY;
      end
      S_READY: begin
        if (weight_start_i) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!weight_start_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_od1   <= '0;
      r_od2   <= '0;
      r_id    <= '0;
      r_od2_v <= 1'b0;
      r_k     <= '0;
    end else begin
      if (w_start_fetch) begin
        r_od1   <= weight_od1_i;
        r_od2   <= weight_od2_i;
        r_id    <= weight_id_i;
        r_od2_v <= w_od2_v_new;
      end
      if (w_fetching && !w_abort && (r_k != 4'd8)) begin
        r_k <= r_k + 4'd1;
      end else begin
        r_k <= '0;
      end
    end
  end

  // Abort flushes the tags so stale returns cannot land after a new bank-2 zero-fill.
  always_ff @(posedge clk) begin
    if (!reset || w_abort) begin
      r_pipe_vld  <= '0;
      r_pipe_bank <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe_k[i] <= '0;
      end
    end else begin
      r_pipe_vld[0]  <= mem_ren_o;
      r_pipe_bank[0] <= (r_state == S_FETCH2);
      r_pipe_k[0]    <= r_k;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_bank[i] <= r_pipe_bank[i-1];
        r_pipe_k[i]    <= r_pipe_k[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bank1 <= '0;
      r_bank2 <= '0;
    end else begin
      if (r_pipe_vld[RD_LAT-1]) begin
        if (r_pipe_bank[RD_LAT-1]) begin
          r_bank2[r_pipe_k[RD_LAT-1]*DW +: DW] <= mem_rdata_i;
        end else begin
          r_bank1[r_pipe_k[RD_LAT-1]*DW +: DW] <= mem_rdata_i;
        end
      end
      if (w_start_fetch && !w_od2_v_new) begin
        r_bank2 <= '0;
      end
    end
  end

  assign mem_ren_o      = w_fetching;
  assign mem_addr_o     = w_fetching ? w_addr : '0;
  assign weight_ready_o = (r_state == S_READY) || (r_state == S_ACTIVE);
  assign w_valid_o      = (r_state == S_ACTIVE);
  assign w1_o           = r_bank1;
  assign w2_o           = r_bank2;

endmodule

// File: tb/tb_weight_controller.sv
// Directed bench: two weight_controller instances (RD_LAT=1 and RD_LAT=3) share stimulus;
// each has its own SRAM model (RD_LAT=1: addr[7:0]; RD_LAT=3: addr[7:0]^0xA5).
module tb_weight_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        prepare = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  od1 = '0;
  logic [7:0]  od2 = '0;
  logic [7:0]  total = '0;
  logic [3:0]  id = '0;

  logic        d1_ren, d1_rdy, d1_vld;
  logic [15:0] d1_addr;
  logic [7:0]  d1_rdata;
  logic [71:0] d1_w1, d1_w2;

  logic        d3_ren, d3_rdy, d3_vld;
  logic [15:0] d3_addr;
  logic [7:0]  d3_rdata, m3a, m3b;
  logic [71:0] d3_w1, d3_w2;

  int total_n = 0;
  int bad_n   = 0;

  logic [71:0] e1a, e2a, e1b, e1c, e2c, e1d;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1_rdata <= d1_addr[7:0];
    m3a      <= d3_addr[7:0] ^ 8'hA5;
    m3b      <= m3a;
    d3_rdata <= m3b;
  end

  weight_controller #(.DW(8), .ADDR_W(16), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .weight_prepare_i(prepare), .weight_start_i(start),
    .weight_od1_i(od1), .weight_od2_i(od2), .weight_id_i(id), .total_od_i(total),
    .mem_ren_o(d1_ren), .mem_addr_o(d1_addr), .mem_rdata_i(d1_rdata),
    .weight_ready_o(d1_rdy), .w_valid_o(d1_vld), .w1_o(d1_w1), .w2_o(d1_w2)
  );

  weight_controller #(.DW(8), .ADDR_W(16), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .weight_prepare_i(prepare), .weight_start_i(start),
    .weight_od1_i(od1), .weight_od2_i(od2), .weight_id_i(id), .total_od_i(total),
    .mem_ren_o(d3_ren), .mem_addr_o(d3_addr), .mem_rdata_i(d3_rdata),
    .weight_ready_o(d3_rdy), .w_valid_o(d3_vld), .w1_o(d3_w1), .w2_o(d3_w2)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] a;
    int seen, nren, r1, r3;

    // {4,3}=67 -> base 603 (0x25B); {5,3}=83 -> 747 (0x2EB); {6,3}=99 -> 891 (0x37B)
    for (int k = 0; k < 9; k++) begin
      e1a[k*8 +: 8] = 8'h5B + 8'(k);
      e2a[k*8 +: 8] = 8'hEB + 8'(k);
      e1b[k*8 +: 8] = 8'h7B + 8'(k);
      e1c[k*8 +: 8] = (8'h5B + 8'(k)) ^ 8'hA5;
      e2c[k*8 +: 8] = (8'hEB + 8'(k)) ^ 8'hA5;
      e1d[k*8 +: 8] = (8'h7B + 8'(k)) ^ 8'hA5;
    end

    // Power-on reset
    step; step;
    check("rst_ctl", {d1_rdy, d1_vld, d1_ren, d1_addr}, 0);
    check("rst_w1", d1_w1, 0);
    check("rst_w2", d1_w2, 0);

    // Reset asserted mid-FETCH1
    reset = 1'b1;
    od1 = 8'd1; od2 = 8'd2; id = 4'd1; total = 8'd8; prepare = 1'b1;
    step;
    step; step; step;
    check("t1_fetching", d1_ren, 1);
    reset = 1'b0; prepare = 1'b0;
    step; step;
    check("t1_ctl", {d1_rdy, d1_vld, d1_ren, d1_addr}, 0);
    check("t1_w1", d1_w1, 0);
    check("t1_w2", d1_w2, 0);
    check("t1_d3", {d3_rdy, d3_vld, d3_ren, d3_w1}, 0);
    reset = 1'b1;
    step; step; step;
    check("t1_idle", {d1_ren, d1_rdy}, 0);

    // Full two-bank fetch
    od1 = 8'd4; od2 = 8'd5; id = 4'd3; total = 8'd8; prepare = 1'b1;
    step;
    for (int k = 0; k < 9; k++) begin
      a = 16'(603 + k);
      check("t2_rd1", {d1_ren, d1_addr}, {1'b1, a});
      step;
    end
    for (int k = 0; k < 9; k++) begin
      a = 16'(747 + k);
      check("t2_rd2", {d1_ren, d1_addr}, {1'b1, a});
      step;
    end
    check("t2_rdy_T19", {d1_ren, d1_rdy}, 0);
    step;
    check("t2_rdy_T20", d1_rdy, 1);
    check("t2_d3_T20", d3_rdy, 0);
    step;
    check("t2_d3_T21", d3_rdy, 0);
    step;
    check("t2_d3_T22", d3_rdy, 1);
    check("t2_w1", d1_w1, e1a);
    check("t2_w2", d1_w2, e2a);
    check("t2_w1_tap0", d1_w1[7:0], 8'h5B);
    check("t2_w2_tap8", d1_w2[71:64], 8'hF3);
    check("t6_w1", d3_w1, e1c);
    check("t6_w2", d3_w2, e2c);

    // Compute phase
    prepare = 1'b0; start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step;
      check("t4_valid", {d1_vld, d1_rdy, d3_vld}, 3'b111);
      check("t4_hold1", d1_w1, e1a);
      check("t4_hold2", d1_w2, e2a);
    end
    start = 1'b0;
    step;
    check("t4_drop", {d1_rdy, d1_vld, d3_rdy, d3_vld}, 0);

    // od2 past last channel: one bank fetched, bank 2 zero-filled
    od1 = 8'd6; od2 = 8'd7; total = 8'd7; prepare = 1'b1;
    step;
    for (int k = 0; k < 9; k++) begin
      a = 16'(891 + k);
      check("t3_rd1", {d1_ren, d1_addr}, {1'b1, a});
      step;
    end
    check("t3_T10", {d1_ren, d1_rdy}, 0);
    step;
    check("t3_rdy_T11", d1_rdy, 1);
    check("t3_w2_zero", d1_w2, 0);
    check("t3_w1", d1_w1, e1b);
    step;
    check("t3_d3_T12", d3_rdy, 0);
    step;
    check("t3_d3_T13", d3_rdy, 1);
    check("t3_d3_w1", d3_w1, e1d);
    check("t3_d3_w2", d3_w2, 0);

    // Back-to-back: ACTIVE -> IDLE -> prepare
    prepare = 1'b0; start = 1'b1;
    step;
    check("b2b_active", d1_vld, 1);
    start = 1'b0; od1 = 8'd4; od2 = 8'd5; total = 8'd8;
    step;
    check("b2b_idle", d1_rdy, 0);
    prepare = 1'b1;
    step;
    check("b2b_first_rd", {d1_ren, d1_addr}, {1'b1, 16'd603});

    // Abort at FETCH2 k=3
    repeat (12) step;
    check("t5_k3", {d1_ren, d1_addr}, {1'b1, 16'd750});
    prepare = 1'b0;
    step;
    check("t5_ren_off", {d1_ren, d3_ren}, 0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (d1_rdy || d3_rdy || d1_ren) seen++;
      step;
    end
    check("t5_no_ready", seen, 0);

    // Re-prepare gives a full fetch
    prepare = 1'b1;
    step;
    nren = 0; r1 = 0; r3 = 0;
    for (int i = 1; i <= 25; i++) begin
      if (d1_ren) nren++;
      if (d1_rdy && r1 == 0) r1 = i;
      if (d3_rdy && r3 == 0) r3 = i;
      step;
    end
    check("t5_nreads", nren, 18);
    check("t5_rdy_lat", r1, 20);
    check("t6_rdy_lat", r3, 22);
    check("t5_w1", d1_w1, e1a);
    check("t5_w2", d1_w2, e2a);
    check("t6_re_w1", d3_w1, e1c);
    check("t6_re_w2", d3_w2, e2c);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
